// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// mem_len codes, requester IDs and RAM strobe levels.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    localparam logic RAM_RD = 1'b0;
    localparam logic RAM_WR = 1'b1;

    // Codes 2 and 3 both mean a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant logic for the shared RAM port. With MEMCTRL_FAIR_ARB_EN defined, a
// last-grant register alternates ties; otherwise MEM always wins a tie.
module mem_ctrl_arb (
`ifdef MEMCTRL_FAIR_ARB_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic idle,
    input  logic rdy,
    input  logic if_req,
    input  logic mem_req,
    input  logic if_flush,
    output logic grant_if,
    output logic grant_mem
);
    import mem_ctrl_pkg::*;

    logic if_ok;
    logic mem_wins;

    assign if_ok = if_req & ~if_flush;

`ifdef MEMCTRL_FAIR_ARB_EN
    req_t last_grant;

    // Reset to IF so the first tie goes to MEM.
    assign mem_wins = mem_req & (~if_ok | (last_grant == REQ_IF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= REQ_IF;
        end else if (grant_mem) begin
            last_grant <= REQ_MEM;
        end else if (grant_if) begin
            last_grant <= REQ_IF;
        end
    end
`else
    assign mem_wins = mem_req;
`endif

    assign grant_mem = idle & rdy & mem_wins;
    assign grant_if  = idle & rdy & if_ok & ~mem_wins;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller shared by instruction fetch and load/store.
// Optional fair tie-breaking is enabled with MEMCTRL_FAIR_ARB_EN.
module mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int IF_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              stall_req
);
    import mem_ctrl_pkg::*;

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] wbuf;
    logic [31:0] rd_buf;
    logic [31:0] rd_next;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx;
    logic        idle, last_rd, last_wr;
    logic        grant_if, grant_mem;

    assign idle      = (state == ST_IDLE);
    assign last_rd   = (cnt == n_bytes);
    assign last_wr   = ((cnt + 3'd1) == n_bytes);
    assign rd_idx    = 2'(cnt - 3'd1);
    assign wr_idx    = 2'(cnt + 3'd1);
    assign stall_req = mem_req & ~mem_done;

    // A requester whose done is showing this cycle is not re-granted.
    mem_ctrl_arb u_arb (
`ifdef MEMCTRL_FAIR_ARB_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .idle      (idle),
        .rdy       (rdy),
        .if_req    (if_req & ~if_done),
        .mem_req   (mem_req & ~mem_done),
        .if_flush  (if_flush),
        .grant_if  (grant_if),
        .grant_mem (grant_mem)
    );

    // Byte i of a read arrives two edges after its address was launched.
    always_comb begin
        rd_next = rd_buf;
        if (cnt != 3'd0) begin
            rd_next[{rd_idx, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_nx = mem_we ? ST_MEM_WR : ST_MEM_RD;
                end else if (grant_if) begin
                    state_nx = ST_IF_RD;
                end
            end
            ST_IF_RD:  if (if_flush || last_rd) state_nx = ST_IDLE;
            ST_MEM_RD: if (last_rd)             state_nx = ST_IDLE;
            ST_MEM_WR: if (last_wr)             state_nx = ST_IDLE;
            default:                            state_nx = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 3'd0;
            n_bytes   <= 3'd0;
            wbuf      <= 32'd0;
            rd_buf    <= 32'd0;
            ram_a     <= '0;
            ram_dout  <= 8'd0;
            ram_wr    <= RAM_RD;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            ram_wr   <= RAM_RD;
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt    <= 3'd0;
                    rd_buf <= 32'd0;
                    if (grant_mem) begin
                        ram_a   <= mem_addr;
                        n_bytes <= len_bytes(mem_len);
                        wbuf    <= mem_wdata;
                        if (mem_we) begin
                            ram_dout <= mem_wdata[7:0];
                            ram_wr   <= RAM_WR;
                        end
                    end else if (grant_if) begin
                        ram_a   <= if_addr;
                        n_bytes <= 3'(IF_BYTES);
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    cnt    <= cnt + 3'd1;
                    rd_buf <= rd_next;
                    if ((cnt + 3'd1) < n_bytes) begin
                        ram_a <= ram_a + ADDR_W'(1);
                    end
                    if (last_rd) begin
                        if (state == ST_MEM_RD) begin
                            mem_done  <= 1'b1;
                            mem_rdata <= rd_next;
                        end else if (!if_flush) begin
                            if_done <= 1'b1;
                            if_inst <= rd_next;
                        end
                    end
                end
                ST_MEM_WR: begin
                    cnt <= cnt + 3'd1;
                    if (last_wr) begin
                        mem_done <= 1'b1;
                    end else begin
                        ram_a    <= ram_a + ADDR_W'(1);
                        ram_dout <= wbuf[{wr_idx, 3'b000} +: 8];
                        ram_wr   <= RAM_WR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
